// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: collects the secret code and guesses from the
// key/switch inputs, drives the scoring-engine handshake, counts attempts and
// declares win or loss.
// Optional build macro MM_SCORE_TIMEOUT_EN adds a scoring-engine response
// timeout with an ERR state from which the current guess can be re-entered.
module mastermind_game_ctrl #(
  parameter int unsigned MAX_GUESSES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [2:0]  digit_in,
  input  logic        score_done,
  input  logic [2:0]  score_red,
  input  logic [2:0]  score_white,
  output logic [11:0] code,
  output logic [11:0] guess,
  output logic        score_start,
  output logic [2:0]  red_out,
  output logic [2:0]  white_out,
  output logic [3:0]  attempt,
  output logic        win,
  output logic        lose,
  output logic        error
);

  localparam int unsigned DIGIT_W  = 3;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned ATT_W    = 4;
  localparam int unsigned ATT_MAX  = 15;
  localparam int unsigned WIN_REDS = 4;

  // Parameter range guards, evaluated at elaboration
  if (MAX_GUESSES < 1 || MAX_GUESSES > ATT_MAX) begin : g_bad_max_guesses
    $error("MAX_GUESSES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    CODE_ENTRY,
    GUESS_ENTRY,
    SCORE_REQ,
    SCORE_WAIT,
    UPDATE,
    WIN,
    LOSE,
    ERR
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                armed;
  logic                press;
  logic [11:0]         code_nxt, guess_nxt;
  logic [2:0]          red_nxt, white_nxt;
  logic [ATT_W-1:0]    attempt_nxt;

`ifdef MM_SCORE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
`endif

  // One press per load assertion; armed re-arms on any cycle with load low
  assign press = load & armed;

  // Next-state and next-datapath values
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    code_nxt    = code;
    guess_nxt   = guess;
    red_nxt     = red_out;
    white_nxt   = white_out;
    attempt_nxt = attempt;
`ifdef MM_SCORE_TIMEOUT_EN
    tmo_nxt     = '0;
`endif
    case (state)
      CODE_ENTRY: begin
        if (press) begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) code_nxt[DIGIT_W*k +: DIGIT_W] = digit_in;
          end
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_W'(DIGITS - 1)) state_nxt = GUESS_ENTRY;
        end
      end
      GUESS_ENTRY: begin
        if (press) begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) guess_nxt[DIGIT_W*k +: DIGIT_W] = digit_in;
          end
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_W'(DIGITS - 1)) state_nxt = SCORE_REQ;
        end
      end
      SCORE_REQ: begin
        state_nxt = SCORE_WAIT;
      end
      SCORE_WAIT: begin
        if (score_done) begin
          red_nxt   = score_red;
          white_nxt = score_white;
          if (attempt != ATT_W'(ATT_MAX)) attempt_nxt = attempt + ATT_W'(1);
          state_nxt = UPDATE;
        end
`ifdef MM_SCORE_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ERR;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      UPDATE: begin
        // A win on the final allowed guess takes priority over the loss
        if (red_out >= 3'(WIN_REDS))                 state_nxt = WIN;
        else if (attempt == ATT_W'(MAX_GUESSES))     state_nxt = LOSE;
        else                                         state_nxt = GUESS_ENTRY;
      end
      WIN, LOSE: begin
        if (press) begin
          code_nxt    = '0;
          guess_nxt   = '0;
          red_nxt     = '0;
          white_nxt   = '0;
          attempt_nxt = '0;
          idx_nxt     = '0;
          state_nxt   = CODE_ENTRY;
        end
      end
      ERR: begin
`ifdef MM_SCORE_TIMEOUT_EN
        if (press) begin
          idx_nxt   = '0;
          state_nxt = GUESS_ENTRY;
        end
`else
        state_nxt = CODE_ENTRY;
`endif
      end
      default: state_nxt = CODE_ENTRY;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= CODE_ENTRY;
      idx         <= '0;
      armed       <= 1'b1;
      code        <= '0;
      guess       <= '0;
      red_out     <= '0;
      white_out   <= '0;
      attempt     <= '0;
      score_start <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      armed       <= ~load;
      code        <= code_nxt;
      guess       <= guess_nxt;
      red_out     <= red_nxt;
      white_out   <= white_nxt;
      attempt     <= attempt_nxt;
      score_start <= (state_nxt == SCORE_REQ);
      win         <= (state_nxt == WIN);
      lose        <= (state_nxt == LOSE);
    end
  end

`ifdef MM_SCORE_TIMEOUT_EN
  // Scoring-engine response timer and error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
      error   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      error   <= (state_nxt == ERR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
